// File: rtl/sr_tx_pkg.sv
// Shared definitions for the serial d-link transmitter: state encoding and default word width.
package sr_tx_pkg;

    localparam int SR_TX_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sr_tx_bitcnt.sv
// Bit-position counter for sr_piso_tx: clears to zero, counts up on enable, flags cnt==WIDTH-1.
module sr_tx_bitcnt
    import sr_tx_pkg::*;
#(
    parameter int WIDTH = SR_TX_WIDTH,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic res,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Terminal at WIDTH-1 means the counter never has to wrap.
    assign term_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/sr_piso_tx.sv
// Parallel-in/serial-out transmitter for the serial d link with frame qualifier and done pulse.
// Optional even-parity trailer bit is enabled by defining SR_TX_PARITY_EN.
module sr_piso_tx
    import sr_tx_pkg::*;
#(
    parameter int WIDTH     = SR_TX_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             d,
    output logic             frame,
    output logic             done
);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, shreg_nx;
    logic             d_q, d_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;
    logic             cnt_clr, cnt_en, cnt_term;
`ifdef SR_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign shreg_nx = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    sr_tx_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk    (clk),
        .res    (res),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_o (cnt_term)
    );

    // d/frame/done are registered, so next-state logic also computes next output values.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        d_d     = d_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef SR_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                d_d     = 1'b0;
                frame_d = 1'b0;
                if (in_valid) begin
                    shreg_d = din;
                    d_d     = head(din);
                    frame_d = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
`ifdef SR_TX_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            SHIFT: begin
                if (EN) begin
                    if (cnt_term) begin
                        cnt_clr = 1'b1;
`ifdef SR_TX_PARITY_EN
                        state_d = PAR;
                        d_d     = par_q;
`else
                        state_d = IDLE;
                        d_d     = 1'b0;
                        frame_d = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        shreg_d = shreg_nx;
                        d_d     = head(shreg_nx);
                        cnt_en  = 1'b1;
                    end
                end
            end
`ifdef SR_TX_PARITY_EN
            PAR: begin
                if (EN) begin
                    state_d = IDLE;
                    d_d     = 1'b0;
                    frame_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                d_d     = 1'b0;
                frame_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            shreg_q <= '0;
            d_q     <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            d_q     <= d_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

`ifdef SR_TX_PARITY_EN
    always_ff @(posedge clk or negedge res) begin
        if (!res)
            par_q <= 1'b0;
        else
            par_q <= par_d;
    end
`endif

    assign in_ready = (state_q == IDLE);
    assign d        = d_q;
    assign frame    = frame_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sr_piso_tx.sv
// Self-checking bench for sr_piso_tx: one MSB-first and one LSB-first instance against a bit-queue model.
module tb_sr_piso_tx;

    localparam int W = 8;
`ifdef SR_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   en, iv, rdy, dd, fr, dn;
    logic [W-1:0] din [2];
    logic         exp_q [$];
    int           passed = 0;
    int           total  = 0;

    sr_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .res(res), .EN(en[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
        .din(din[0]), .d(dd[0]), .frame(fr[0]), .done(dn[0])
    );

    sr_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .res(res), .EN(en[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
        .din(din[1]), .d(dd[1]), .frame(fr[1]), .done(dn[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle_outputs(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("%s_d%0d", tag, s), dd[s], 0);
            chk($sformatf("%s_frame%0d", tag, s), fr[s], 0);
            chk($sformatf("%s_done%0d", tag, s), dn[s], 0);
            chk($sformatf("%s_ready%0d", tag, s), rdy[s], 1);
        end
    endtask

    // Called just after a negedge: offer a word for the next rising edge.
    task automatic present(input int sel, input logic [W-1:0] w);
        chk($sformatf("accept_ready%0d", sel), rdy[sel], 1);
        iv[sel]  = 1'b1;
        din[sel] = w;
        en[sel]  = 1'($urandom_range(0, 1));
    endtask

    // mode 0: EN always 1, mode 1: EN toggles starting low, mode 2: random EN.
    task automatic run(input int sel, input logic [W-1:0] w, input int mode,
                       input bit hold_valid, input bit chain, input logic [W-1:0] nxt);
        int   cyc = 0;
        logic e;
        exp_q.delete();
        for (int i = 0; i < W; i++)
            exp_q.push_back(sel == 0 ? w[W-1-i] : w[i]);
`ifdef SR_TX_PARITY_EN
        exp_q.push_back(^w);
`endif
        @(posedge clk);
        @(negedge clk);
        iv[sel] = hold_valid;
        while (exp_q.size() > 0 && cyc < 4 * NB + 8) begin
            chk("bit_d", dd[sel], exp_q[0]);
            chk("bit_frame", fr[sel], 1);
            chk("bit_done", dn[sel], 0);
            chk("bit_ready", rdy[sel], 0);
            case (mode)
                0:       e = 1'b1;
                1:       e = cyc[0];
                default: e = 1'($urandom_range(0, 1));
            endcase
            en[sel]  = e;
            din[sel] = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (e) void'(exp_q.pop_front());
            cyc++;
        end
        chk("frame_timeout", exp_q.size(), 0);
        chk("done_pulse", dn[sel], 1);
        chk("gap_frame", fr[sel], 0);
        chk("gap_d", dd[sel], 0);
        chk("done_ready", rdy[sel], 1);
        if (chain) begin
            present(sel, nxt);
        end else begin
            iv[sel] = 1'b0;
            en[sel] = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            chk("done_once", dn[sel], 0);
            chk("idle_frame", fr[sel], 0);
        end
    endtask

    initial begin
        iv = '0; en = '0; din[0] = '0; din[1] = '0;

        // Reset held: outputs must stay quiet while inputs toggle.
        repeat (4) begin
            @(negedge clk);
            idle_outputs("reset");
            iv = 2'($urandom); en = 2'($urandom);
            din[0] = W'($urandom); din[1] = W'($urandom);
        end
        @(negedge clk);
        iv = '0; res = 1'b1;
        @(negedge clk);
        idle_outputs("post_reset");

        present(0, 8'hA5);  run(0, 8'hA5, 0, 1'b0, 1'b0, 8'h00);
        present(1, 8'h01);  run(1, 8'h01, 1, 1'b0, 1'b0, 8'h00);

        // Back-to-back: second word accepted in the done cycle.
        present(0, 8'hFF);  run(0, 8'hFF, 0, 1'b1, 1'b1, 8'h00);
        run(0, 8'h00, 0, 1'b1, 1'b0, 8'h00);

        // Asynchronous reset mid-frame after three bits of C3.
        present(0, 8'hC3);
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("c3_bit", dd[0], (8'hC3 >> (7 - i)) & 1);
            chk("c3_frame", fr[0], 1);
            en[0] = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        chk("c3_pre_frame", fr[0], 1);
        #2 res = 1'b0;
        #1 idle_outputs("midreset");
        repeat (3) begin
            iv = 2'($urandom); en = 2'($urandom);
            @(negedge clk);
            idle_outputs("midreset_hold");
        end
        iv = '0; res = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_outputs("post_midreset");
        present(0, 8'h3C);  run(0, 8'h3C, 0, 1'b0, 1'b0, 8'h00);

        // in_valid held with din churning during the frame.
        present(1, 8'h96);  run(1, 8'h96, 2, 1'b1, 1'b0, 8'h00);
        present(0, 8'h5A);  run(0, 8'h5A, 2, 1'b1, 1'b0, 8'h00);

        repeat (20) begin
            int           s;
            logic [W-1:0] w;
            s = int'($urandom_range(0, 1));
            w = W'($urandom);
            present(s, w);
            run(s, w, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0, 8'h00);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
